retry_start_replay: RTL and testbench
=====================================

Name: retry_start_replay

Overview:
- Initiating end of the retry protocol. Sits upstream of a time-redundant operation, before the matching retry-end block.
- Tags each incoming item with a wrapping ID and keeps a copy in an ID-indexed replay buffer.
- Forwards items downstream through a one-stage output register.
- When the retry end sends back an ID, the block re-issues the stored item under the same ID, with priority over new input.

Parameters:
- DataWidth, 32, payload width in bits
- IDSize, 2, ID width; replay buffer depth = 2**IDSize entries; must be >= 1

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- data_i  in  DataWidth  upstream payload
- valid_i  in  1  upstream valid
- ready_o  out  1  upstream ready
- data_o  out  DataWidth  downstream payload
- id_o  out  IDSize  ID tag of downstream payload
- valid_o  out  1  downstream valid
- ready_i  in  1  downstream ready
- retry_id_i  in  IDSize  ID requested for re-issue (retry interface "id")
- retry_valid_i  in  1  retry request valid (retry interface "valid")
- retry_ready_o  out  1  retry request accepted (retry interface "ready")
- retry_id_feedback_o  out  IDSize  next ID to be assigned (retry interface "id_feedback")
- retry_lock_i  in  1  retry end blocks new items (retry interface "lock")
- unknown_retry_o  out  1  one-cycle pulse: retry for an ID never written since reset

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - valid_o=0, data_o=0, id_o=0, unknown_retry_o=0.
  - next_id=0, so retry_id_feedback_o=0.
  - All buffer entries=0; written bitmap all 0.
- Reset mid-operation: any held output is dropped, no handshake completes in that cycle, and all state returns to reset values on the next edge.
- Output slot free: out_free = !valid_o || ready_i.
- Priority, evaluated each cycle:
  1. Retry: retry_valid_i && out_free.
  2. New item: valid_i && out_free && !retry_valid_i && !retry_lock_i.
- Handshake signals (combinational):
  - retry_ready_o = out_free.
  - ready_o = out_free && !retry_valid_i && !retry_lock_i.
  - Neither ready depends combinationally on its own valid.
- New-item accept (valid_i && ready_o), at the next edge:
  - buf[next_id] <= data_i; written[next_id] <= 1.
  - data_o <= data_i; id_o <= next_id; valid_o <= 1.
  - next_id <= next_id+1, modulo 2**IDSize; wraps from 2**IDSize-1 to 0.
- Retry accept (retry_valid_i && retry_ready_o), with written[retry_id_i]=1:
  - data_o <= buf[retry_id_i]; id_o <= retry_id_i; valid_o <= 1.
  - next_id, buffer and written bitmap are unchanged.
- Retry accept with written[retry_id_i]=0:
  - Request is consumed and the output register is not loaded.
  - valid_o <= 0 if it was being drained this cycle.
  - unknown_retry_o=1 for exactly the following cycle.
- No accept while out_free: valid_o <= 0 at the edge if ready_i drained it.
- Stall (valid_o && !ready_i): data_o, id_o and valid_o are held stable. Both ready outputs are 0.
- Latency: accept to valid_o is 1 cycle; throughput is 1 item per cycle when ready_i=1.
- retry_id_feedback_o = next_id, registered. The retry end uses it to avoid requesting IDs about to be overwritten.
- Wrap-around overwrite is the retry end's responsibility. When the end cannot tolerate it, it holds retry_lock_i=1.
- retry_lock_i blocks only new items; retries still proceed under lock.
- Buffer read for retry is combinational on retry_id_i. The buffer is written only on new-item accept, so a retry never races a write to the same entry.
- No internal FIFO: upstream backpressure is handled solely through ready_o.

Test Plan:
- Streaming (IDSize=2, DataWidth=8; ready_i=1; inputs 0xA0,0xA1,0xA2,0xA3,0xA4 back-to-back) -> outputs one cycle after each accept with id_o 0,1,2,3,0; retry_id_feedback_o steps 1,2,3,0,1.
- Retry priority: valid_i=1 with data 0xB5 while retry_valid_i=1, retry_id_i=1 after 0xA1 was sent -> data_o=0xA1, id_o=1, ready_o=0 that cycle; 0xB5 follows next cycle with the next sequential ID; next_id does not advance on the retry.
- Backpressure: ready_i=0 for 3 cycles while valid_o=1 (data 0xC0, id 2) -> data_o and id_o are stable; ready_o=0 and retry_ready_o=0; item transfers on the cycle ready_i returns to 1.
- Lock: retry_lock_i=1 with valid_i=1 -> ready_o=0 and no new items; retry of id 0 is still issued with the stored payload; releasing lock resumes acceptance.
- Unknown retry: directly after reset, retry_valid_i=1, retry_id_i=3 -> retry_ready_o=1, valid_o stays 0, unknown_retry_o pulses high for 1 cycle.
- Reset mid-stall: rst_i=1 while valid_o=1 and ready_i=0 -> next cycle valid_o=0, retry_id_feedback_o=0; a subsequent retry of the old id reports unknown_retry_o.

Source files
------------

// File: rtl/retry_start_replay.sv
// retry_start_replay: initiating end of the retry protocol.
// Tags each accepted item with a wrapping ID, keeps a copy in an ID-indexed
// replay buffer, and forwards items through a single output register.
// A retry request re-issues the stored payload under its original ID and
// takes priority over new upstream items.
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; ready never depends on its own valid, and a held output
// (valid_o && !ready_i) keeps data_o/id_o/valid_o stable.
module retry_start_replay #(
  parameter int DataWidth = 32,
  parameter int IDSize    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic [IDSize-1:0]    id_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  input  logic [IDSize-1:0]    retry_id_i,
  input  logic                 retry_valid_i,
  output logic                 retry_ready_o,
  output logic [IDSize-1:0]    retry_id_feedback_o,
  input  logic                 retry_lock_i,
  output logic                 unknown_retry_o
);

  localparam int Depth = 1 << IDSize;

  logic [DataWidth-1:0] r_buf [Depth];
  logic [Depth-1:0]     r_written;
  logic [IDSize-1:0]    r_next_id;
  logic [DataWidth-1:0] r_data;
  logic [IDSize-1:0]    r_id;
  logic                 r_valid;
  logic                 r_unknown;

  logic w_out_free;
  logic w_retry_acc;
  logic w_new_acc;
  logic w_retry_known;

  // Output slot can take a new value when empty or being drained this cycle.
  // Readies are forced low during reset so no handshake completes then.
  always_comb begin
    w_out_free    = !r_valid || ready_i;
    retry_ready_o = w_out_free && !rst_i;
    ready_o       = w_out_free && !retry_valid_i && !retry_lock_i && !rst_i;
    w_retry_acc   = retry_valid_i && retry_ready_o;
    w_new_acc     = valid_i && ready_o;
    w_retry_known = r_written[retry_id_i];
  end

  // Output register, replay buffer, written bitmap and ID counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_id      <= '0;
      r_next_id <= '0;
      r_unknown <= 1'b0;
      r_written <= '0;
      for (int i = 0; i < Depth; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_unknown <= 1'b0;
      if (w_retry_acc) begin
        if (w_retry_known) begin
          r_data  <= r_buf[retry_id_i];
          r_id    <= retry_id_i;
          r_valid <= 1'b1;
        end else begin
          // Unknown ID: request is consumed, the slot (free by definition) empties.
          r_valid   <= 1'b0;
          r_unknown <= 1'b1;
        end
      end else if (w_new_acc) begin
        r_buf[r_next_id]     <= data_i;
        r_written[r_next_id] <= 1'b1;
        r_data               <= data_i;
        r_id                 <= r_next_id;
        r_valid              <= 1'b1;
        r_next_id            <= r_next_id + IDSize'(1);
      end else if (w_out_free) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o              = r_data;
  assign id_o                = r_id;
  assign valid_o             = r_valid;
  assign retry_id_feedback_o = r_next_id;
  assign unknown_retry_o     = r_unknown;

endmodule

// File: tb/tb_retry_start_replay.sv
// Directed bench for retry_start_replay with DataWidth=8, IDSize=2.
module tb_retry_start_replay;

  localparam int DW = 8;
  localparam int IW = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_o;
  logic [IW-1:0] id_o;
  logic          valid_o;
  logic          ready_i;
  logic [IW-1:0] retry_id_i;
  logic          retry_valid_i;
  logic          retry_ready_o;
  logic [IW-1:0] retry_id_feedback_o;
  logic          retry_lock_i;
  logic          unknown_retry_o;

  int n_cmp = 0;
  int n_err = 0;

  retry_start_replay #(.DataWidth(DW), .IDSize(IW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .id_o(id_o), .valid_o(valid_o),
    .ready_i(ready_i), .retry_id_i(retry_id_i), .retry_valid_i(retry_valid_i),
    .retry_ready_o(retry_ready_o), .retry_id_feedback_o(retry_id_feedback_o),
    .retry_lock_i(retry_lock_i), .unknown_retry_o(unknown_retry_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // Advance one rising edge, land 1ns after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; data_i = '0; valid_i = 1'b0; ready_i = 1'b1;
    retry_id_i = '0; retry_valid_i = 1'b0; retry_lock_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0h want 0", valid_o); end
    n_cmp++; if (data_o !== 8'h00) begin n_err++; $display("FAIL rst_data: got %0h want 0", data_o); end
    n_cmp++; if (id_o !== 2'd0) begin n_err++; $display("FAIL rst_id: got %0h want 0", id_o); end
    n_cmp++; if (retry_id_feedback_o !== 2'd0) begin n_err++; $display("FAIL rst_fb: got %0h want 0", retry_id_feedback_o); end
    n_cmp++; if (unknown_retry_o !== 1'b0) begin n_err++; $display("FAIL rst_unknown: got %0h want 0", unknown_retry_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0h want 1", ready_o); end
  endtask

  task automatic test_unknown_retry();
    retry_valid_i = 1'b1; retry_id_i = 2'd3;
    #1;
    n_cmp++; if (retry_ready_o !== 1'b1) begin n_err++; $display("FAIL unk_rready: got %0h want 1", retry_ready_o); end
    n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL unk_ready: got %0h want 0", ready_o); end
    step();
    retry_valid_i = 1'b0;
    #1;
    n_cmp++; if (unknown_retry_o !== 1'b1) begin n_err++; $display("FAIL unk_pulse: got %0h want 1", unknown_retry_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL unk_valid: got %0h want 0", valid_o); end
    step();
    n_cmp++; if (unknown_retry_o !== 1'b0) begin n_err++; $display("FAIL unk_pulse_end: got %0h want 0", unknown_retry_o); end
  endtask

  // A0..A4 back to back; IDs 0,1,2,3,0 and feedback 1,2,3,0,1.
  task automatic test_streaming();
    logic [IW-1:0] exp_id [5];
    logic [IW-1:0] exp_fb [5];
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_fb = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      valid_i = 1'b1; data_i = 8'hA0 + 8'(k);
      #1;
      n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL str_ready[%0d]: got %0h want 1", k, ready_o); end
      step();
      n_cmp++; if (valid_o !== 1'b1 || data_o !== 8'hA0 + 8'(k) || id_o !== exp_id[k])
        begin n_err++; $display("FAIL str_out[%0d]: got v%0h d%0h id%0h want v1 d%0h id%0h", k, valid_o, data_o, id_o, 8'hA0 + 8'(k), exp_id[k]); end
      n_cmp++; if (retry_id_feedback_o !== exp_fb[k]) begin n_err++; $display("FAIL str_fb[%0d]: got %0h want %0h", k, retry_id_feedback_o, exp_fb[k]); end
    end
    valid_i = 1'b0;
    step();
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL str_drain: got %0h want 0", valid_o); end
  endtask

  // Buffer now: 0=A4 1=A1 2=A2 3=A3, next_id=1.
  task automatic test_retry_priority();
    valid_i = 1'b1; data_i = 8'hB5; retry_valid_i = 1'b1; retry_id_i = 2'd1;
    #1;
    n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL pri_ready: got %0h want 0", ready_o); end
    step();
    retry_valid_i = 1'b0;
    #1;
    n_cmp++; if (valid_o !== 1'b1 || data_o !== 8'hA1 || id_o !== 2'd1)
      begin n_err++; $display("FAIL pri_retry_out: got v%0h d%0h id%0h want v1 dA1 id1", valid_o, data_o, id_o); end
    n_cmp++; if (retry_id_feedback_o !== 2'd1) begin n_err++; $display("FAIL pri_fb_hold: got %0h want 1", retry_id_feedback_o); end
    step();
    valid_i = 1'b0;
    n_cmp++; if (valid_o !== 1'b1 || data_o !== 8'hB5 || id_o !== 2'd1)
      begin n_err++; $display("FAIL pri_new_out: got v%0h d%0h id%0h want v1 dB5 id1", valid_o, data_o, id_o); end
    n_cmp++; if (retry_id_feedback_o !== 2'd2) begin n_err++; $display("FAIL pri_fb_adv: got %0h want 2", retry_id_feedback_o); end
    step();
  endtask

  // Buffer: 0=A4 1=B5 2=A2 3=A3, next_id=2.
  task automatic test_backpressure();
    valid_i = 1'b1; data_i = 8'hC0;
    step();
    valid_i = 1'b1; data_i = 8'hDD; ready_i = 1'b0;
    #1;
    n_cmp++; if (valid_o !== 1'b1 || data_o !== 8'hC0 || id_o !== 2'd2)
      begin n_err++; $display("FAIL bp_load: got v%0h d%0h id%0h want v1 dC0 id2", valid_o, data_o, id_o); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (ready_o !== 1'b0 || retry_ready_o !== 1'b0)
        begin n_err++; $display("FAIL bp_ready[%0d]: got r%0h rr%0h want 0 0", c, ready_o, retry_ready_o); end
      step();
      n_cmp++; if (valid_o !== 1'b1 || data_o !== 8'hC0 || id_o !== 2'd2 || retry_id_feedback_o !== 2'd3)
        begin n_err++; $display("FAIL bp_hold[%0d]: got v%0h d%0h id%0h fb%0h want v1 dC0 id2 fb3", c, valid_o, data_o, id_o, retry_id_feedback_o); end
    end
    ready_i = 1'b1; valid_i = 1'b0;
    step();
    n_cmp++; if (valid_o !== 1'b0 || retry_id_feedback_o !== 2'd3)
      begin n_err++; $display("FAIL bp_release: got v%0h fb%0h want v0 fb3", valid_o, retry_id_feedback_o); end
  endtask

  // Buffer: 0=A4 1=B5 2=C0 3=A3, next_id=3.
  task automatic test_lock();
    retry_lock_i = 1'b1; valid_i = 1'b1; data_i = 8'hE0;
    #1;
    n_cmp++; if (ready_o !== 1'b0 || retry_ready_o !== 1'b1)
      begin n_err++; $display("FAIL lk_ready: got r%0h rr%0h want 0 1", ready_o, retry_ready_o); end
    step();
    n_cmp++; if (valid_o !== 1'b0 || retry_id_feedback_o !== 2'd3)
      begin n_err++; $display("FAIL lk_block: got v%0h fb%0h want v0 fb3", valid_o, retry_id_feedback_o); end
    retry_valid_i = 1'b1; retry_id_i = 2'd0;
    step();
    retry_valid_i = 1'b0;
    n_cmp++; if (valid_o !== 1'b1 || data_o !== 8'hA4 || id_o !== 2'd0)
      begin n_err++; $display("FAIL lk_retry: got v%0h d%0h id%0h want v1 dA4 id0", valid_o, data_o, id_o); end
    step();
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL lk_drain: got %0h want 0", valid_o); end
    retry_lock_i = 1'b0;
    #1;
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL lk_unlock_ready: got %0h want 1", ready_o); end
    step();
    valid_i = 1'b0;
    n_cmp++; if (valid_o !== 1'b1 || data_o !== 8'hE0 || id_o !== 2'd3 || retry_id_feedback_o !== 2'd0)
      begin n_err++; $display("FAIL lk_resume: got v%0h d%0h id%0h fb%0h want v1 dE0 id3 fb0", valid_o, data_o, id_o, retry_id_feedback_o); end
    step();
  endtask

  task automatic test_reset_mid_stall();
    valid_i = 1'b1; data_i = 8'hF0;
    step();
    valid_i = 1'b0; ready_i = 1'b0;
    step();
    n_cmp++; if (valid_o !== 1'b1 || id_o !== 2'd0)
      begin n_err++; $display("FAIL rs_stall: got v%0h id%0h want v1 id0", valid_o, id_o); end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    n_cmp++; if (valid_o !== 1'b0 || retry_id_feedback_o !== 2'd0 || data_o !== 8'h00)
      begin n_err++; $display("FAIL rs_clear: got v%0h fb%0h d%0h want v0 fb0 d0", valid_o, retry_id_feedback_o, data_o); end
    ready_i = 1'b1; retry_valid_i = 1'b1; retry_id_i = 2'd0;
    #1;
    n_cmp++; if (retry_ready_o !== 1'b1) begin n_err++; $display("FAIL rs_rready: got %0h want 1", retry_ready_o); end
    step();
    retry_valid_i = 1'b0;
    n_cmp++; if (unknown_retry_o !== 1'b1 || valid_o !== 1'b0)
      begin n_err++; $display("FAIL rs_unknown: got u%0h v%0h want u1 v0", unknown_retry_o, valid_o); end
  endtask

  initial begin
    test_reset();
    test_unknown_retry();
    test_streaming();
    test_retry_priority();
    test_backpressure();
    test_lock();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
